// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : mips_pkg
//  Description : Shared MIPS pipeline constants (load types, write-back
//                source selects) and the W-stage pipeline register layout.
//  Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

    // Load type encodings; 5..7 are unused and behave as LW
    localparam logic [2:0] LOAD_LW  = 3'd0;
    localparam logic [2:0] LOAD_LB  = 3'd1;
    localparam logic [2:0] LOAD_LBU = 3'd2;
    localparam logic [2:0] LOAD_LH  = 3'd3;
    localparam logic [2:0] LOAD_LHU = 3'd4;

    // Write-back source selects
    localparam logic [1:0] WB_ALU  = 2'd0;
    localparam logic [1:0] WB_MEM  = 2'd1;
    localparam logic [1:0] WB_LINK = 2'd2;
    localparam logic [1:0] WB_HILO = 2'd3;

    // Return-address offset for jal/jalr (skips the delay slot)
    localparam logic [31:0] LINK_OFFSET = 32'd8;

    // M/W pipeline register contents
    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic        reg_we;
        logic [4:0]  a3;
        logic [1:0]  wb_sel;
        logic [2:0]  load_type;
        logic [1:0]  addr_lo;
        logic [31:0] alu_res;
        logic [31:0] mem_rdata;
        logic [31:0] hilo;
    } w_reg_t;

endpackage
`default_nettype wire

// File: rtl/wb_stage_if.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage_if
//  Description : M-stage results into write-back, and the register-file
//                write port plus W forwarding bus out of it.
//  Revision    : 1.0 - initial release
// ============================================================================
interface wb_stage_if;

    // M-stage results
    logic        m_valid;
    logic [31:0] m_pc;
    logic        m_reg_we;
    logic [4:0]  m_a3;
    logic [1:0]  m_wb_sel;
    logic [2:0]  m_load_type;
    logic [1:0]  m_addr_lo;
    logic [31:0] m_alu_res;
    logic [31:0] m_mem_rdata;
    logic [31:0] m_hilo;

    // Register file write port
    logic        grf_we;
    logic [4:0]  grf_a3;
    logic [31:0] grf_wd;
    logic [31:0] grf_pc;

    // W-stage forwarding
    logic        fwd_w_valid;
    logic [4:0]  fwd_w_a3;
    logic [31:0] fwd_w_data;

    // Write-back stage: consumes M results, initiates register-file writes
    modport master (
        input  m_valid, m_pc, m_reg_we, m_a3, m_wb_sel, m_load_type,
               m_addr_lo, m_alu_res, m_mem_rdata, m_hilo,
        output grf_we, grf_a3, grf_wd, grf_pc,
               fwd_w_valid, fwd_w_a3, fwd_w_data
    );

    // Surrounding pipeline / register file side
    modport slave (
        output m_valid, m_pc, m_reg_we, m_a3, m_wb_sel, m_load_type,
               m_addr_lo, m_alu_res, m_mem_rdata, m_hilo,
        input  grf_we, grf_a3, grf_wd, grf_pc,
               fwd_w_valid, fwd_w_a3, fwd_w_data
    );

endinterface
`default_nettype wire

// File: rtl/wb_stage_load_ext.sv
`default_nettype none
// ============================================================================
//  Module      : load_ext
//  Description : Sub-word load extraction and sign/zero extension of the raw
//                aligned memory word (little-endian byte order).
//  Revision    : 1.0 - initial release
// ============================================================================
module load_ext
    import mips_pkg::*;
(
    input  wire logic [31:0] rdata,
    input  wire logic [1:0]  addr_lo,
    input  wire logic [2:0]  load_type,
    output logic      [31:0] ext_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // Pick the addressed byte/half, then extend according to load type
    always_comb begin
        case (addr_lo)
            2'd1:    w_byte = rdata[15:8];
            2'd2:    w_byte = rdata[23:16];
            2'd3:    w_byte = rdata[31:24];
            default: w_byte = rdata[7:0];
        endcase

        // addr_lo[0] is ignored for halves; misalignment is trapped upstream
        w_half = addr_lo[1] ? rdata[31:16] : rdata[15:0];

        case (load_type)
            LOAD_LB:  ext_data = {{24{w_byte[7]}}, w_byte};
            LOAD_LBU: ext_data = {24'd0, w_byte};
            LOAD_LH:  ext_data = {{16{w_half[15]}}, w_half};
            LOAD_LHU: ext_data = {16'd0, w_half};
            default:  ext_data = rdata;
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
//  Module      : wb_stage
//  Description : MIPS write-back stage. Holds the M/W pipeline register,
//                selects write-back data, drives the register-file write
//                port and W forwarding bus, and keeps retire/cycle counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_stage
    import mips_pkg::*;
(
    input  wire logic        clk,
    input  wire logic        reset,
    input  wire logic        flush_w,
    wb_stage_if.master       bus,
    output logic      [31:0] retire_cnt,
    output logic      [31:0] cycle_cnt
);

    w_reg_t      r_w;
    logic [31:0] r_retire_cnt;
    logic [31:0] r_cycle_cnt;
    logic [31:0] w_load_data;
    logic [31:0] w_wd;

    // M/W pipeline register; a flush loads an all-zero bubble
    always_ff @(posedge clk) begin
        if (reset || flush_w) begin
            r_w <= '0;
        end else begin
            r_w.valid     <= bus.m_valid;
            r_w.pc        <= bus.m_pc;
            r_w.reg_we    <= bus.m_reg_we;
            r_w.a3        <= bus.m_a3;
            r_w.wb_sel    <= bus.m_wb_sel;
            r_w.load_type <= bus.m_load_type;
            r_w.addr_lo   <= bus.m_addr_lo;
            r_w.alu_res   <= bus.m_alu_res;
            r_w.mem_rdata <= bus.m_mem_rdata;
            r_w.hilo      <= bus.m_hilo;
        end
    end

    // Performance counters; retire counts the instruction in W this cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_retire_cnt <= 32'd0;
            r_cycle_cnt  <= 32'd0;
        end else begin
            r_retire_cnt <= r_retire_cnt + {31'd0, r_w.valid};
            r_cycle_cnt  <= r_cycle_cnt + 32'd1;
        end
    end

    load_ext u_load_ext (
        .rdata     (r_w.mem_rdata),
        .addr_lo   (r_w.addr_lo),
        .load_type (r_w.load_type),
        .ext_data  (w_load_data)
    );

    // Write-back source select
    always_comb begin
        case (r_w.wb_sel)
            WB_MEM:  w_wd = w_load_data;
            WB_LINK: w_wd = r_w.pc + LINK_OFFSET;
            WB_HILO: w_wd = r_w.hilo;
            default: w_wd = r_w.alu_res;
        endcase
    end

    // $0 writes still reach the file (for its log) but are never forwarded
    assign bus.grf_we      = r_w.valid & r_w.reg_we;
    assign bus.grf_a3      = r_w.a3;
    assign bus.grf_wd      = w_wd;
    assign bus.grf_pc      = r_w.pc;
    assign bus.fwd_w_valid = r_w.valid & r_w.reg_we & (r_w.a3 != 5'd0);
    assign bus.fwd_w_a3    = r_w.a3;
    assign bus.fwd_w_data  = w_wd;

    assign retire_cnt = r_retire_cnt;
    assign cycle_cnt  = r_cycle_cnt;

endmodule
`default_nettype wire
